// File: rtl/ld_seq_pkg.sv
// ld_seq_pkg: shared types and constants for latch_load_sequencer.
//   state_e      : frame FSM states
//   cls_e        : address-byte class field
//   ERR_*        : Err_Code values
//   START_BIT    : bit position of the start marker in the address byte
//   class_bytes(): number of data bytes carried by a frame of a given class
package ld_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    STROBE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_16   = 2'b00,
    CLS_20   = 2'b01,
    CLS_48   = 2'b10,
    CLS_RSVD = 2'b11
  } cls_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam int START_BIT = 7;

  localparam logic [2:0] BYTES_16 = 3'd2;
  localparam logic [2:0] BYTES_20 = 3'd3;
  localparam logic [2:0] BYTES_48 = 3'd6;

  function automatic logic [2:0] class_bytes(input cls_e c);
    case (c)
      CLS_16:  class_bytes = BYTES_16;
      CLS_20:  class_bytes = BYTES_20;
      CLS_48:  class_bytes = BYTES_48;
      default: class_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/latch_load_sequencer_if.sv
// latch_load_sequencer_if: host byte handshake.
//   Byte_in    : host byte
//   Byte_valid : host has a byte this cycle
//   Byte_ready : sequencer accepts a byte this cycle
// Handshake: a byte moves on the rising clock edge where Byte_valid && Byte_ready
// are both high; the host holds Byte_in stable while Byte_valid is high and
// Byte_ready is low, and Byte_ready never depends on Byte_valid.
interface latch_load_sequencer_if;
  logic [7:0] Byte_in;
  logic       Byte_valid;
  logic       Byte_ready;

  modport master (output Byte_in, output Byte_valid, input  Byte_ready);
  modport slave  (input  Byte_in, input  Byte_valid, output Byte_ready);
endinterface

// File: rtl/ld_seq_timeout.sv
// ld_seq_timeout: idle-cycle counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart counting (byte transferred, or no frame in progress)
//   expire   : high on the TIMEOUT_CYC-th consecutive uncleared cycle
module ld_seq_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = !clear && (cnt_q == CW'(TIMEOUT_CYC - 1));
    if (clear || expire) cnt_d = '0;
    else                 cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/latch_load_sequencer.sv
// latch_load_sequencer: byte-stream frame loader for the latch data region.
// Frame = address byte, 2/3/6 data bytes MSB first, XOR checksum byte.
// Ports:
//   Clock, Reset : clock, asynchronous active-high reset
//   byte_if      : host byte handshake (slave side)
//   Data48B_out, Data20B_out, Data16B_out : shared latch data buses
//   EN_Vector    : one-hot single-cycle load strobe
//   Busy         : frame in progress (DATA, CHECK, STROBE)
//   Frame_Err    : single-cycle error pulse
//   Err_Code     : last error (none/address/checksum/timeout)
//   State_dbg    : current FSM state
module latch_load_sequencer import ld_seq_pkg::*; #(
  parameter int NUM_TARGETS = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   Clock,
  input  logic                   Reset,
  latch_load_sequencer_if.slave  byte_if,
  output logic [47:0]            Data48B_out,
  output logic [19:0]            Data20B_out,
  output logic [15:0]            Data16B_out,
  output logic [NUM_TARGETS-1:0] EN_Vector,
  output logic                   Busy,
  output logic                   Frame_Err,
  output logic [1:0]             Err_Code,
  output state_e                 State_dbg
);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  cls_e        cls_q, cls_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [47:0] asm_q, asm_d;
  logic [47:0] d48_q, d48_d;
  logic [19:0] d20_q, d20_d;
  logic [15:0] d16_q, d16_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;

  logic       xfer;
  logic [7:0] b;
  logic       addr_ok;
  logic       csum_match;
  logic       in_frame;
  logic       tmo_clear;
  logic       tmo_expire;

  assign b          = byte_if.Byte_in;
  assign xfer       = byte_if.Byte_valid && byte_if.Byte_ready;
  assign addr_ok    = b[START_BIT] && (b[6:5] != CLS_RSVD) &&
                      (int'(b[4:0]) < NUM_TARGETS);
  assign csum_match = (b == csum_q);
  // Only DATA and CHECK wait on the host; the counter idles at zero elsewhere.
  assign in_frame   = (state_q == DATA) || (state_q == CHECK);
  assign tmo_clear  = !in_frame || xfer;

  ld_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (tmo_clear),
    .expire (tmo_expire)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. tmo_expire can only be high with no transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (xfer && addr_ok) state_d = DATA;
      DATA: begin
        if (tmo_expire)                  state_d = IDLE;
        else if (xfer && cnt_q == 3'd1)  state_d = CHECK;
      end
      CHECK: begin
        if (tmo_expire) state_d = IDLE;
        else if (xfer)  state_d = csum_match ? STROBE : IDLE;
      end
      STROBE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    byte_if.Byte_ready = (state_q != STROBE);
    Busy               = (state_q != IDLE);
    EN_Vector          = '0;
    if (state_q == STROBE) EN_Vector[idx_q] = 1'b1;
  end

  // Datapath next values
  always_comb begin
    idx_d       = idx_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    d48_d       = d48_q;
    d20_d       = d20_q;
    d16_d       = d16_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (addr_ok) begin
            idx_d  = b[4:0];
            cls_d  = cls_e'(b[6:5]);
            cnt_d  = class_bytes(cls_e'(b[6:5]));
            csum_d = b;
            asm_d  = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_ADDR;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          asm_d  = {asm_q[39:0], b};
          csum_d = csum_q ^ b;
          cnt_d  = cnt_q - 3'd1;
        end else if (tmo_expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (csum_match) begin
            // Bus is loaded on the CHECK->STROBE edge so it is valid with EN.
            case (cls_q)
              CLS_16:  d16_d = asm_q[15:0];
              CLS_20:  d20_d = asm_q[19:0];
              CLS_48:  d48_d = asm_q;
              default: ;
            endcase
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end else if (tmo_expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx_q       <= '0;
      cls_q       <= CLS_16;
      cnt_q       <= '0;
      csum_q      <= '0;
      asm_q       <= '0;
      d48_q       <= '0;
      d20_q       <= '0;
      d16_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      idx_q       <= idx_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
      d48_q       <= d48_d;
      d20_q       <= d20_d;
      d16_q       <= d16_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign Data48B_out = d48_q;
  assign Data20B_out = d20_q;
  assign Data16B_out = d16_q;
  assign Frame_Err   = err_pulse_q;
  assign Err_Code    = err_code_q;
  assign State_dbg   = state_q;

endmodule

// File: tb/tb_latch_load_sequencer.sv
// tb_latch_load_sequencer: self-checking bench for latch_load_sequencer.
module tb_latch_load_sequencer;
  import ld_seq_pkg::*;

  localparam int NT  = 32;
  localparam int TMO = 1024;
  localparam int W   = 85; // {is_err, code[1:0], en[31:0], cls[1:0], data[47:0]}

  logic              clk;
  logic              rst;
  logic [47:0]       d48;
  logic [19:0]       d20;
  logic [15:0]       d16;
  logic [NT-1:0]     en_vec;
  logic              busy;
  logic              frame_err;
  logic [1:0]        err_code;
  state_e            state_dbg;

  latch_load_sequencer_if bif();

  latch_load_sequencer #(.NUM_TARGETS(NT), .TIMEOUT_CYC(TMO)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .byte_if     (bif),
    .Data48B_out (d48),
    .Data20B_out (d20),
    .Data16B_out (d16),
    .EN_Vector   (en_vec),
    .Busy        (busy),
    .Frame_Err   (frame_err),
    .Err_Code    (err_code),
    .State_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [47:0]  m48, m20, m16;

  function automatic logic [W-1:0] mk_ev(input logic is_err, input logic [1:0] code,
                                         input logic [31:0] en, input logic [1:0] cls,
                                         input logic [47:0] data);
    mk_ev = {is_err, code, en, cls, data};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] ev;
    if (rst) begin
      m48 = '0; m20 = '0; m16 = '0;
    end else if (en_vec != '0 || frame_err) begin
      check("en_err_exclusive", 64'(en_vec != '0 && frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {32'd0, en_vec}, 64'd0);
      end else begin
        ev = exp_q.pop_front();
        if (ev[84]) begin
          check("err_code", 64'(err_code), 64'(ev[83:82]));
          check("err_no_en", 64'(en_vec), 64'd0);
        end else begin
          check("en_vector", 64'(en_vec), 64'(ev[81:50]));
          case (ev[49:48])
            2'b00:   m16 = {32'd0, ev[15:0]};
            2'b01:   m20 = {28'd0, ev[19:0]};
            default: m48 = ev[47:0];
          endcase
        end
        check("data48", 64'(d48), 64'(m48));
        check("data20", 64'(d20), 64'(m20));
        check("data16", 64'(d16), 64'(m16));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bif.Byte_in    = b;
    bif.Byte_valid = 1'b1;
    while (!bif.Byte_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bif.Byte_valid = 1'b0;
  endtask

  // Sends a frame; when use_cs is set the given checksum replaces the correct one.
  task automatic send_frame(input logic [7:0] addr, input logic [47:0] payload,
                            input int nbytes, input logic use_cs, input logic [7:0] cs_val);
    logic [7:0]  cs;
    logic [7:0]  sent_cs;
    logic [31:0] en;
    logic        good;
    cs = addr;
    for (int i = nbytes - 1; i >= 0; i--) cs = cs ^ payload[8*i +: 8];
    sent_cs = use_cs ? cs_val : cs;
    good    = (sent_cs == cs);
    en      = 32'd1 << addr[4:0];
    if (good) exp_q.push_back(mk_ev(1'b0, 2'd0, en, addr[6:5], payload));
    else      exp_q.push_back(mk_ev(1'b1, ERR_CSUM, 32'd0, 2'd0, 48'd0));
    send_byte(addr);
    for (int i = nbytes - 1; i >= 0; i--) send_byte(payload[8*i +: 8]);
    send_byte(sent_cs);
    @(negedge clk);
    if (good) begin
      check("strobe_latency", 64'(en_vec), 64'(en));
      check("ready_in_strobe", 64'(bif.Byte_ready), 64'd0);
      check("busy_in_strobe", 64'(busy), 64'd1);
    end else begin
      check("csum_err_pulse", 64'(frame_err), 64'd1);
      check("csum_no_busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    check("en_single_cycle", 64'(en_vec), 64'd0);
    check("err_single_cycle", 64'(frame_err), 64'd0);
  endtask

  task automatic send_bad_addr(input logic [7:0] b);
    exp_q.push_back(mk_ev(1'b1, ERR_ADDR, 32'd0, 2'd0, 48'd0));
    send_byte(b);
    @(negedge clk);
    check("addr_err_pulse", 64'(frame_err), 64'd1);
    check("addr_err_idle", 64'(state_dbg), 64'(IDLE));
    check("addr_err_busy", 64'(busy), 64'd0);
  endtask

  task automatic send_random_frame();
    logic [1:0]  cls;
    logic [4:0]  idx;
    logic [47:0] pl;
    int          nb;
    cls = 2'($urandom_range(0, 2));
    idx = 5'($urandom_range(0, NT - 1));
    pl  = {16'($urandom), 32'($urandom)};
    nb  = (cls == 2'b00) ? 2 : (cls == 2'b01) ? 3 : 6;
    if (nb < 6) pl = pl & ((48'd1 << (8 * nb)) - 48'd1);
    send_frame({1'b1, cls, idx}, pl, nb, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst            = 1'b1;
    bif.Byte_in    = 8'h00;
    bif.Byte_valid = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(bif.Byte_ready), 64'd1);
    check("rst_en", 64'(en_vec), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_d48", 64'(d48), 64'd0);
    check("rst_d20", 64'(d20), 64'd0);
    check("rst_d16", 64'(d16), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed frames from the three classes
    send_frame(8'h85, 48'h1234, 2, 1'b0, 8'h00);
    send_frame(8'hC1, 48'h0123456789AB, 6, 1'b0, 8'h00);
    send_frame(8'hA3, 48'hF56789, 3, 1'b0, 8'h00);
    check("d20_value", 64'(d20), 64'h56789);
    // Wrong checksum
    send_frame(8'h85, 48'h1234, 2, 1'b1, 8'h00);
    check("csum_err_code_hold", 64'(err_code), 64'(ERR_CSUM));
    check("d16_kept", 64'(d16), 64'h1234);

    // Bad addresses, then a good frame
    send_bad_addr(8'hE0);
    send_bad_addr(8'h05);
    check("addr_err_code_hold", 64'(err_code), 64'(ERR_ADDR));
    send_frame(8'h9F, 48'hBEEF, 2, 1'b0, 8'h00);

    // Timeout inside DATA
    exp_q.push_back(mk_ev(1'b1, ERR_TMO, 32'd0, 2'd0, 48'd0));
    send_byte(8'h85);
    send_byte(8'h12);
    k = 0;
    while (!frame_err && k < TMO + 8) begin
      @(negedge clk);
      k++;
      if (k == TMO - 2) check("tmo_busy_before", 64'(busy), 64'd1);
    end
    check("tmo_window", 64'(k >= TMO && k <= TMO + 2), 64'd1);
    check("tmo_busy_after", 64'(busy), 64'd0);
    send_frame(8'h85, 48'hCAFE, 2, 1'b0, 8'h00);
    check("d16_after_tmo", 64'(d16), 64'hCAFE);

    // Random frames
    for (int i = 0; i < 6; i++) send_random_frame();

    // Reset mid 48-bit frame after 3 data bytes
    send_byte(8'hC1);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_en", 64'(en_vec), 64'd0);
    check("mid_rst_d48", 64'(d48), 64'd0);
    check("mid_rst_d20", 64'(d20), 64'd0);
    check("mid_rst_d16", 64'(d16), 64'd0);
    check("mid_rst_err_code", 64'(err_code), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(8'hC1, 48'h0123456789AB, 6, 1'b0, 8'h00);
    send_frame(8'hA3, 48'hF56789, 3, 1'b0, 8'h00);

    repeat (4) @(negedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
